// File: rtl/motor_endstop_guard.sv
// Step/dir guard for one axis: debounced endstops, directional step blocking,
// absolute position counter and trip interrupt. Optional MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN adds blocked_cnt.
module motor_endstop_guard #(
  parameter int unsigned DEBOUNCE_N  = 500,
  parameter bit          ENDSTOP_INV = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_in,
  input  logic               dir_in,
  input  logic               endstop_min_raw,
  input  logic               endstop_max_raw,
  input  logic               arm,
  input  logic               clear,
  input  logic               set_pos,
  input  logic signed [31:0] pos_val,
  output logic               step_out,
  output logic               dir_out,
  output logic signed [31:0] pos,
  output logic               min_hit,
  output logic               max_hit,
  output logic               tripped,
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
  output logic [15:0]        blocked_cnt,
`endif
  output logic               trip_int
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_BLOCK = 2'd2;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_N - 1);

  // Bit 0 is the min endstop, bit 1 the max endstop.
  logic [1:0]       raw_act;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0][15:0] db_cnt_q, db_cnt_d;

  logic             step_q;
  logic             dir_q;
  logic [1:0]       state_q, state_d;
  logic signed [31:0] pos_q, pos_d;
  logic             tripped_q, tripped_d;
  logic             trip_int_q, trip_int_d;

  logic             step_rise;
  logic             block;
  logic             pass_entry;
  logic             block_entry;

  assign raw_act = {endstop_max_raw, endstop_min_raw} ^ {2{ENDSTOP_INV}};

  // NOTE: next-state logic is combinational with a default assignment for every
  // signal before any branch; an unassigned path would infer a latch.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = 16'd0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = ~deb_q[i];
        db_cnt_d[i] = 16'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= raw_act;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign min_hit = deb_q[0];
  assign max_hit = deb_q[1];

  // step_q resets high so a step_in already high at reset release is no edge.
  assign step_rise   = step_in & ~step_q;
  assign block       = arm & ((dir_in & max_hit) | (~dir_in & min_hit));
  assign pass_entry  = (state_q == ST_IDLE) & step_rise & ~block;
  assign block_entry = (state_q == ST_IDLE) & step_rise & block;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (step_rise) state_d = block ? ST_BLOCK : ST_PASS;
      end
      ST_PASS, ST_BLOCK: begin
        if (!step_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (set_pos) begin
      pos_d = pos_val;
    end else if (pass_entry) begin
      pos_d = dir_in ? pos_q + 32'sd1 : pos_q - 32'sd1;
    end
  end

  // A blocked step on the same edge as clear leaves the flag set.
  always_comb begin
    tripped_d  = tripped_q;
    trip_int_d = block_entry;
    if (block_entry) begin
      tripped_d = 1'b1;
    end else if (clear) begin
      tripped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q     <= 1'b1;
      dir_q      <= 1'b0;
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      tripped_q  <= 1'b0;
      trip_int_q <= 1'b0;
    end else begin
      step_q     <= step_in;
      dir_q      <= dir_in;
      state_q    <= state_d;
      pos_q      <= pos_d;
      tripped_q  <= tripped_d;
      trip_int_q <= trip_int_d;
    end
  end

  assign step_out = (state_q == ST_PASS);
  assign dir_out  = dir_q;
  assign pos      = pos_q;
  assign tripped  = tripped_q;
  assign trip_int = trip_int_q;

`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
  logic [15:0] blocked_cnt_q, blocked_cnt_d;

  always_comb begin
    blocked_cnt_d = blocked_cnt_q;
    if (clear) begin
      blocked_cnt_d = 16'd0;
    end else if (block_entry && blocked_cnt_q != 16'hFFFF) begin
      blocked_cnt_d = blocked_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blocked_cnt_q <= 16'd0;
    else       blocked_cnt_q <= blocked_cnt_d;
  end

  assign blocked_cnt = blocked_cnt_q;
`endif

endmodule

// File: tb/tb_motor_endstop_guard.sv
// Directed bench for motor_endstop_guard (DEBOUNCE_N = 8): vector table for
// step/position behaviour, hand sequences for debounce, blocking and reset.
module tb_motor_endstop_guard;

  logic               clk;
  logic               reset;
  logic               step_in;
  logic               dir_in;
  logic               endstop_min_raw;
  logic               endstop_max_raw;
  logic               arm;
  logic               clear;
  logic               set_pos;
  logic signed [31:0] pos_val;
  logic               step_out;
  logic               dir_out;
  logic signed [31:0] pos;
  logic               min_hit;
  logic               max_hit;
  logic               tripped;
  logic               trip_int;
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
  logic [15:0]        blocked_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  motor_endstop_guard #(.DEBOUNCE_N(8), .ENDSTOP_INV(1'b0)) dut (
    .clk             (clk),
    .reset           (reset),
    .step_in         (step_in),
    .dir_in          (dir_in),
    .endstop_min_raw (endstop_min_raw),
    .endstop_max_raw (endstop_max_raw),
    .arm             (arm),
    .clear           (clear),
    .set_pos         (set_pos),
    .pos_val         (pos_val),
    .step_out        (step_out),
    .dir_out         (dir_out),
    .pos             (pos),
    .min_hit         (min_hit),
    .max_hit         (max_hit),
    .tripped         (tripped),
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
    .blocked_cnt     (blocked_cnt),
`endif
    .trip_int        (trip_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic        dir;
    logic        armv;
    logic        setp;
    logic [31:0] pval;
    logic        exp_step;
    logic        exp_dir;
    logic [31:0] exp_pos;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic d, input logic a, input logic sp,
                              input logic [31:0] pv, input logic es, input logic ed,
                              input logic [31:0] ep);
    vec_t v;
    v.step = s; v.dir = d; v.armv = a; v.setp = sp; v.pval = pv;
    v.exp_step = es; v.exp_dir = ed; v.exp_pos = ep;
    return v;
  endfunction

  int trip_seen;
  int hi_cycles;
  logic [31:0] pos_ref;

  initial begin
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b0;
    endstop_min_raw = 1'b0; endstop_max_raw = 1'b0;
    arm = 1'b1; clear = 1'b0; set_pos = 1'b0; pos_val = '0;

    //            step dir arm set  pos_val        step_o dir_o pos
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 32'd0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'd1);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'd1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'd1);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'd0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 32'hFFFF_FFFF);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'hFFFF_FFFF);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd100,      1'b0, 1'b1, 32'd100);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd5,        1'b1, 1'b1, 32'd5);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 32'd5);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'h8000_0000);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 32'h8000_0000);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 32'h8000_0001);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 32'h8000_0001);

    // Reset state
    #12;
    check("reset step_out", {31'd0, step_out}, 32'd0);
    check("reset pos", pos, 32'd0);
    check("reset min_hit", {31'd0, min_hit}, 32'd0);
    check("reset max_hit", {31'd0, max_hit}, 32'd0);
    check("reset tripped", {31'd0, tripped}, 32'd0);
    check("reset trip_int", {31'd0, trip_int}, 32'd0);
    #10 reset = 1'b0;
    tick();

    // Vector table: forwarding, direction, wrap, load priority, disarmed
    for (int i = 0; i < 16; i++) begin
      step_in = vecs[i].step; dir_in = vecs[i].dir; arm = vecs[i].armv;
      set_pos = vecs[i].setp; pos_val = vecs[i].pval;
      tick();
      check($sformatf("vec%0d step_out", i), {31'd0, step_out}, {31'd0, vecs[i].exp_step});
      check($sformatf("vec%0d dir_out", i), {31'd0, dir_out}, {31'd0, vecs[i].exp_dir});
      check($sformatf("vec%0d pos", i), pos, vecs[i].exp_pos);
      check($sformatf("vec%0d trip_int", i), {31'd0, trip_int}, 32'd0);
    end
    set_pos = 1'b0; arm = 1'b1;

    // Pass-through: 10 pulses of 3 cycles toward max from pos 0
    set_pos = 1'b1; pos_val = 32'd0; tick(); set_pos = 1'b0;
    trip_seen = 0;
    dir_in = 1'b1;
    for (int p = 0; p < 10; p++) begin
      step_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        check($sformatf("pass p%0d c%0d high", p, c), {31'd0, step_out}, 32'd1);
        trip_seen += int'(trip_int);
      end
      step_in = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        check($sformatf("pass p%0d c%0d low", p, c), {31'd0, step_out}, 32'd0);
        trip_seen += int'(trip_int);
      end
    end
    check("pass pos", pos, 32'd10);
    check("pass trip_int count", trip_seen, 32'd0);

    // Debounce: 5-cycle glitch ignored, held edge seen exactly 10 cycles later
    endstop_max_raw = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    endstop_max_raw = 1'b0;
    hi_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      hi_cycles += int'(max_hit);
    end
    check("glitch max_hit cycles", hi_cycles, 32'd0);
    endstop_max_raw = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    check("debounce max_hit at 9", {31'd0, max_hit}, 32'd0);
    tick();
    check("debounce max_hit at 10", {31'd0, max_hit}, 32'd1);

    // Directional block: 3 steps into max blocked, 2 away forwarded
    trip_seen = 0;
    hi_cycles = 0;
    dir_in = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step_in = 1'b1;
      tick();
      check($sformatf("block p%0d trip_int", p), {31'd0, trip_int}, 32'd1);
      trip_seen += int'(trip_int);
      hi_cycles += int'(step_out);
      tick();
      trip_seen += int'(trip_int);
      hi_cycles += int'(step_out);
      step_in = 1'b0;
      tick();
      trip_seen += int'(trip_int);
    end
    check("block trip_int count", trip_seen, 32'd3);
    check("block step_out cycles", hi_cycles, 32'd0);
    check("block tripped", {31'd0, tripped}, 32'd1);
    check("block pos", pos, 32'd10);
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
    check("blocked_cnt 3", {16'd0, blocked_cnt}, 32'd3);
`endif
    dir_in = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step_in = 1'b1;
      tick();
      check($sformatf("away p%0d step_out", p), {31'd0, step_out}, 32'd1);
      step_in = 1'b0;
      tick();
    end
    check("away pos", pos, 32'd8);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear tripped", {31'd0, tripped}, 32'd0);
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
    check("blocked_cnt cleared", {16'd0, blocked_cnt}, 32'd0);
`endif

    // clear coincident with a blocked step: tripped ends set
    dir_in = 1'b1; step_in = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; step_in = 1'b0;
    check("clear+block tripped", {31'd0, tripped}, 32'd1);
    check("clear+block trip_int", {31'd0, trip_int}, 32'd1);
`ifdef MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN
    check("clear+block blocked_cnt", {16'd0, blocked_cnt}, 32'd0);
`endif
    tick();
    clear = 1'b1; tick(); clear = 1'b0;

    // Disarmed: step into active max passes, counts, never trips
    arm = 1'b0; dir_in = 1'b1; step_in = 1'b1;
    tick();
    check("disarm step_out", {31'd0, step_out}, 32'd1);
    check("disarm trip_int", {31'd0, trip_int}, 32'd0);
    check("disarm pos", pos, 32'd9);
    step_in = 1'b0; tick(); arm = 1'b1;

    // Both endstops hit: step toward min also blocks
    endstop_min_raw = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("min_hit", {31'd0, min_hit}, 32'd1);
    dir_in = 1'b0; step_in = 1'b1;
    tick();
    check("both step_out", {31'd0, step_out}, 32'd0);
    check("both trip_int", {31'd0, trip_int}, 32'd1);
    step_in = 1'b0; tick();
    clear = 1'b1; tick(); clear = 1'b0;

    // Mid-pulse endstop change: 20-cycle pulse forwarded in full
    endstop_max_raw = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("max released", {31'd0, max_hit}, 32'd0);
    dir_in = 1'b1; step_in = 1'b1; endstop_max_raw = 1'b1;
    hi_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      hi_cycles += int'(step_out);
    end
    check("mid max_hit", {31'd0, max_hit}, 32'd1);
    step_in = 1'b0;
    tick();
    check("mid step_out cycles", hi_cycles, 32'd20);
    check("mid step_out low", {31'd0, step_out}, 32'd0);
    check("mid pos", pos, 32'd10);
    step_in = 1'b1;
    tick();
    check("after mid blocked", {31'd0, step_out}, 32'd0);
    check("after mid trip_int", {31'd0, trip_int}, 32'd1);
    step_in = 1'b0; tick();

    // Reset mid-pulse: async drop, held step_in ignored until next edge
    arm = 1'b0; step_in = 1'b1;
    tick();
    check("rst pre step_out", {31'd0, step_out}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst async step_out", {31'd0, step_out}, 32'd0);
    check("rst pos", pos, 32'd0);
    check("rst tripped", {31'd0, tripped}, 32'd0);
    #2 reset = 1'b0;
    hi_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      hi_cycles += int'(step_out);
    end
    check("rst held step ignored", hi_cycles, 32'd0);
    step_in = 1'b0; tick();
    step_in = 1'b1; tick();
    check("rst new edge step_out", {31'd0, step_out}, 32'd1);
    check("rst new edge pos", pos, 32'd1);
    step_in = 1'b0; tick();
    check("rst new edge fall", {31'd0, step_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_endstop_guard.md
# motor_endstop_guard

Sits between `motor_step_gen` and the motor driver pins of one axis: forwards step/dir, suppresses any step pulse that would drive the axis further into an active endstop, and keeps an absolute step-position counter. Endstop inputs are raw switch pins, synchronized and debounced here. A trip raises a one-cycle interrupt pulse for the `s3g_executor` interrupt inputs. Position and status are read back through executor in-registers.

## Interface
- `DEBOUNCE_N`, 500: consecutive stable cycles required to change a debounced endstop state; legal range 1..65535.
- `ENDSTOP_INV`, 0: when 1, raw endstop pins are active-low.
- `clk` in 1: system clock; the block's only clock.
- `reset` in 1: asynchronous, active-high reset.
- `step_in` in 1: step pulse from `motor_step_gen`. One step per rising edge; high for at least 1 cycle.
- `dir_in` in 1: direction. 1 = toward max, +1; 0 = toward min, −1.
- `endstop_min_raw`, `endstop_max_raw` in 1 each: asynchronous switch pins.
- `arm` in 1: level. 1 = blocking enabled.
- `clear` in 1: strobe; clears `tripped`.
- `set_pos` in 1: strobe; loads `pos_val` into `pos`.
- `pos_val` in 32: signed position load value.
- `step_out` out 1: gated step to driver.
- `dir_out` out 1: direction to driver.
- `pos` out 32: signed absolute position.
- `min_hit`, `max_hit` out 1 each: debounced endstop states, active-high after inversion.
- `tripped` out 1: sticky flag, set by a blocked step.
- `trip_int` out 1: one-cycle pulse on each blocked step.
- `blocked_cnt` out 16: only with `MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN`.

## Operation
- **Endstop path:**
  - raw XOR `ENDSTOP_INV` → 2-flop synchronizer → debouncer.
  - Each endstop has a 16-bit counter. It resets to 0 whenever the synced value equals the debounced value, and increments otherwise.
  - When the counter reaches `DEBOUNCE_N`, the debounced value flips and the counter returns to 0.
- **Step FSM:** states IDLE, PASS, BLOCK.
  - Rising edge of `step_in` is detected by comparing `step_in` with its 1-cycle delayed copy.
  - In IDLE, a rising edge evaluates `block = arm & ((dir_in & max_hit) | (~dir_in & min_hit))`.
  - `block`=0 → PASS. `block`=1 → BLOCK.
  - PASS and BLOCK return to IDLE in the cycle `step_in` is sampled low.
  - A rising edge of `step_in` cannot occur in PASS or BLOCK, since it needs a low sample first.
- **Gating:** `step_out` is high exactly while in PASS.
  - The decision is frozen for the whole pulse; endstop changes or `clear` mid-pulse do not truncate or extend it.
- **Direction:** `dir_out` is `dir_in` registered every cycle, regardless of gating.
- **Position:** on entry to PASS, `pos` ± 1 per the sampled `dir_in`. It wraps modulo 2^32, so 0x7FFFFFFF + 1 = 0x80000000. BLOCK entries do not count.
- **Set vs. step:** `set_pos` loads `pos_val`. If it coincides with a PASS entry, the load wins and that step is not counted; the step is still forwarded.
- **Trip:** entry to BLOCK pulses `trip_int` and sets `tripped`.
  - `clear` resets `tripped`.
  - If `clear` coincides with a BLOCK entry, `tripped` ends at 1.
- **Disarmed:** `arm`=0 never blocks and never trips. Counting is unaffected.
- **Blocking scope:** steps away from an active endstop always pass. With both endstops hit and `arm`=1, all steps block.

## Timing
- **Reset values:** all outputs 0, `pos`=0, debounced states 0 (not hit), FSM IDLE, debounce counters 0.
- **Step latency:** `step_out` rises 1 cycle after `step_in` is first sampled high. It falls 1 cycle after `step_in` is sampled low, preserving pulse width.
- **Same-edge updates:** `pos` and `trip_int`/`tripped` update on the same clock edge that `step_out` rises (PASS) or would rise (BLOCK).
- **`dir_out` latency:** 1 cycle, matching `step_out`, so driver setup relative to step is preserved.
- **Endstop latency:** `min_hit`/`max_hit` change 2 + `DEBOUNCE_N` cycles after a clean raw transition. A glitch shorter than `DEBOUNCE_N` synced cycles produces no change.
- **Reset mid-pulse:** `step_out` drops immediately (asynchronously). After reset, an already-high `step_in` is not a rising edge and is ignored until it goes low.

## Configuration
- `MOTOR_ENDSTOP_GUARD_BLOCKED_CNT_EN` defined:
  - `blocked_cnt` port exists. It counts BLOCK entries, saturates at 0xFFFF, and is cleared by `clear` (clear wins on coincidence), reset 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Pass-through:** `arm`=1, no endstops; 10 pulses of 3 cycles, `dir_in`=1 → 10 `step_out` pulses of 3 cycles each, delayed 1 cycle; `pos`=10; `trip_int` never asserts.
- **Debounce:** `DEBOUNCE_N`=8; pulse `endstop_max_raw` high for 5 cycles → `max_hit` stays 0. Hold high → `max_hit`=1 exactly 10 cycles after the raw edge.
- **Directional block:** `max_hit`=1, `arm`=1; 3 steps with `dir_in`=1 → no `step_out`, 3 `trip_int` pulses, `tripped`=1, `pos` unchanged. 2 steps with `dir_in`=0 → forwarded, `pos`−2. `clear` → `tripped`=0. With the macro, `blocked_cnt`=3, then 0 after `clear`.
- **Mid-pulse change:** start a 20-cycle PASS pulse, assert `max_hit` at cycle 5 → full 20-cycle `step_out` pulse. Next step with `dir_in`=1 is blocked.
- **Wrap and load:** `set_pos` with `pos_val`=0x7FFFFFFF, then 1 step with `dir_in`=1 → `pos`=0x80000000. `set_pos` with `pos_val`=5 coincident with a PASS entry → `pos`=5, step still forwarded.
- **Reset mid-pulse:** assert `reset` during a PASS pulse → `step_out`=0 immediately. After release with `step_in` still high, no output pulse occurs until the next rising edge.
